// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types for the IF/ID fetch-decode buffer: packet layout, FSM states, stall counter width.
package fetch_decode_buffer_pkg;

  localparam int PKG_XLEN               = 64;
  localparam int PKG_INSTRUCTION_LENGTH = PKG_XLEN / 2;
  localparam int STALL_CNT_W            = 32;

  typedef struct packed {
    logic [PKG_XLEN-1:0]               PC;
    logic [PKG_INSTRUCTION_LENGTH-1:0] instruction;
  } fetch_packet_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fetch_decode_buffer.sv
// IF/ID two-entry skid buffer: accepted packet reaches decode next cycle; fetch_ready is registered.
// Optional FETCH_DECODE_BUFFER_STALL_CNT_EN adds a saturating stall_count output.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int XLEN               = PKG_XLEN,
  parameter int INSTRUCTION_LENGTH = XLEN / 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [XLEN-1:0]               PC_in,
  input  logic [INSTRUCTION_LENGTH-1:0] instruction_in,
  output logic                          decode_valid,
  input  logic                          decode_ready,
  output logic [XLEN-1:0]               PC_out,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_out
`ifdef FETCH_DECODE_BUFFER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]        stall_count
`endif
);

  buf_state_e    state_q, state_d;
  fetch_packet_t main_q, main_d;
  fetch_packet_t skid_q, skid_d;
  fetch_packet_t in_pkt;
  logic          fetch_ready_q;
  logic          in_fire;
  logic          out_fire;

  assign in_pkt          = '{PC: PC_in, instruction: instruction_in};
  assign in_fire         = fetch_valid & fetch_ready_q;
  assign out_fire        = decode_valid & decode_ready;
  assign decode_valid    = (state_q != EMPTY);
  assign fetch_ready     = fetch_ready_q;
  assign PC_out          = main_q.PC;
  assign instruction_out = main_q.instruction;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_pkt;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_pkt;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_pkt;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Redirect kills everything, including this cycle's fetch input.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      fetch_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      fetch_ready_q <= (state_d != FULL);
    end
  end

`ifdef FETCH_DECODE_BUFFER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (decode_valid && !decode_ready && (stall_q != '1)) begin
      stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: scoreboard monitor plus per-scenario tasks.
module tb_fetch_decode_buffer;
  import fetch_decode_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, decode_ready;
  logic        fetch_ready, decode_valid;
  logic [63:0] PC_in, PC_out;
  logic [31:0] instruction_in, instruction_out;
`ifdef FETCH_DECODE_BUFFER_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int total  = 0;
  int passed = 0;
  fetch_packet_t sb[$];

  always #5 clk = ~clk;

  fetch_decode_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .PC_in           (PC_in),
    .instruction_in  (instruction_in),
    .decode_valid    (decode_valid),
    .decode_ready    (decode_ready),
    .PC_out          (PC_out),
    .instruction_out (instruction_out)
`ifdef FETCH_DECODE_BUFFER_STALL_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc);
    fetch_valid    = 1'b1;
    PC_in          = pc;
    instruction_in = mk_instr(pc);
  endtask

  // Scoreboard: sampled mid-cycle, reflects what the next rising edge will do.
  always @(negedge clk) begin
    fetch_packet_t exp_pkt;
    if (rst) begin
      sb.delete();
    end else begin
      total++;
      if (decode_valid !== (sb.size() != 0))
        $display("FAIL mon_decode_valid t=%0t got %b want %b", $time, decode_valid, sb.size() != 0);
      else
        passed++;
      if (decode_valid && decode_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL mon_unexpected_pkt t=%0t got PC %h want none", $time, PC_out);
        end else begin
          exp_pkt = sb.pop_front();
          if (PC_out !== exp_pkt.PC || instruction_out !== exp_pkt.instruction)
            $display("FAIL mon_pkt t=%0t got %h/%h want %h/%h", $time, PC_out, instruction_out,
                     exp_pkt.PC, exp_pkt.instruction);
          else
            passed++;
        end
      end
      if (flush)
        sb.delete();
      else if (fetch_valid && fetch_ready)
        sb.push_back('{PC: PC_in, instruction: instruction_in});
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; decode_ready = 1'b0;
    PC_in = '0; instruction_in = '0;
    step(); step(); step();
    total++;
    if (decode_valid !== 1'b0 || fetch_ready !== 1'b0 || PC_out !== 64'h0 || instruction_out !== 32'h0)
      $display("FAIL reset_state got v=%b r=%b pc=%h i=%h want 0/0/0/0", decode_valid, fetch_ready, PC_out, instruction_out);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (fetch_ready !== 1'b1 || decode_valid !== 1'b0)
      $display("FAIL reset_release got r=%b v=%b want 1/0", fetch_ready, decode_valid);
    else passed++;
  endtask

  task automatic test_stream();
    decode_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(64'(i * 8));
      step();
      total++;
      if (decode_valid !== 1'b1 || PC_out !== 64'(i * 8) || fetch_ready !== 1'b1)
        $display("FAIL stream_%0d got v=%b pc=%h r=%b want 1/%h/1", i, decode_valid, PC_out, fetch_ready, i * 8);
      else passed++;
    end
    fetch_valid = 1'b0;
    step();
    total++;
    if (decode_valid !== 1'b0)
      $display("FAIL stream_drain got v=%b want 0", decode_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    decode_ready = 1'b0;
    offer(64'h8);
    step();
    offer(64'h10);
    step();
    fetch_valid = 1'b0;
    total++;
    if (fetch_ready !== 1'b0 || decode_valid !== 1'b1 || PC_out !== 64'h8)
      $display("FAIL bp_full got r=%b v=%b pc=%h want 0/1/8", fetch_ready, decode_valid, PC_out);
    else passed++;
    step();
    total++;
    if (PC_out !== 64'h8 || instruction_out !== mk_instr(64'h8))
      $display("FAIL bp_stable got pc=%h i=%h want 8/%h", PC_out, instruction_out, mk_instr(64'h8));
    else passed++;
    decode_ready = 1'b1;
    step();
    total++;
    if (PC_out !== 64'h10 || fetch_ready !== 1'b1)
      $display("FAIL bp_release got pc=%h r=%b want 10/1", PC_out, fetch_ready);
    else passed++;
    step();
    total++;
    if (decode_valid !== 1'b0)
      $display("FAIL bp_drain got v=%b want 0", decode_valid);
    else passed++;
  endtask

  task automatic test_flush_full();
    decode_ready = 1'b0;
    offer(64'h20); step();
    offer(64'h28); step();
    offer(64'h18);
    flush = 1'b1;
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    total++;
    if (decode_valid !== 1'b0 || PC_out !== 64'h0 || instruction_out !== 32'h0 || fetch_ready !== 1'b1)
      $display("FAIL flush_full got v=%b pc=%h i=%h r=%b want 0/0/0/1", decode_valid, PC_out, instruction_out, fetch_ready);
    else passed++;
    decode_ready = 1'b1;
    offer(64'h40);
    step();
    fetch_valid = 1'b0;
    total++;
    if (decode_valid !== 1'b1 || PC_out !== 64'h40 || instruction_out !== mk_instr(64'h40))
      $display("FAIL flush_after got v=%b pc=%h want 1/40", decode_valid, PC_out);
    else passed++;
    step();
  endtask

  task automatic test_flush_outfire();
    decode_ready = 1'b0;
    offer(64'h48); step();
    decode_ready = 1'b1;
    flush = 1'b1;
    offer(64'h50);
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    total++;
    if (decode_valid !== 1'b0 || PC_out !== 64'h0)
      $display("FAIL flush_outfire got v=%b pc=%h want 0/0", decode_valid, PC_out);
    else passed++;
    step();
    total++;
    if (decode_valid !== 1'b0)
      $display("FAIL flush_no_dup got v=%b want 0", decode_valid);
    else passed++;
  endtask

  task automatic test_reset_full();
    decode_ready = 1'b0;
    offer(64'h60); step();
    offer(64'h68); step();
    fetch_valid = 1'b0;
    rst = 1'b1;
    step();
    total++;
    if (decode_valid !== 1'b0 || fetch_ready !== 1'b0 || PC_out !== 64'h0)
      $display("FAIL reset_full got v=%b r=%b pc=%h want 0/0/0", decode_valid, fetch_ready, PC_out);
    else passed++;
    rst = 1'b0;
    step();
    decode_ready = 1'b1;
    offer(64'h70);
    step();
    fetch_valid = 1'b0;
    total++;
    if (PC_out !== 64'h70 || instruction_out !== mk_instr(64'h70) || decode_valid !== 1'b1)
      $display("FAIL reset_first_pkt got pc=%h i=%h v=%b want 70/%h/1", PC_out, instruction_out, decode_valid, mk_instr(64'h70));
    else passed++;
    step();
  endtask

`ifdef FETCH_DECODE_BUFFER_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst = 1'b1; fetch_valid = 1'b0; decode_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    total++;
    if (stall_count !== 32'd0)
      $display("FAIL stall_init got %0d want 0", stall_count);
    else passed++;
    offer(64'h80);
    step();
    fetch_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (stall_count !== 32'd5)
      $display("FAIL stall_five got %0d want 5", stall_count);
    else passed++;
    // The flush cycle itself still has a stalled valid head.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    total++;
    if (stall_count !== 32'd6)
      $display("FAIL stall_flush got %0d want 6", stall_count);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if (stall_count !== 32'd0)
      $display("FAIL stall_rst got %0d want 0", stall_count);
    else passed++;
    rst = 1'b0;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_outfire();
    test_reset_full();
`ifdef FETCH_DECODE_BUFFER_STALL_CNT_EN
    test_stall_cnt();
`endif
    step();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_empty got %0d pending want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
